// File: rtl/mem_pkg.sv
// Shared definitions for the word-memory initiators: memory geometry and the
// copy engine's state encoding.
package mem_pkg;
  localparam int MEM_SIZE = 256;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;
endpackage

// File: rtl/mem_copy_range_chk.sv
// Combinational bounds check: flags a block that would run past the end of
// memory from either its source or destination base.
module mem_copy_range_chk #(
  parameter int MEM_SIZE = mem_pkg::MEM_SIZE,
  parameter int LEN_W    = 9
) (
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             err_o
);
  import mem_pkg::*;

  logic [32:0] src_end, dst_end;

  // One extra bit so a base near 2^32 cannot wrap past the check.
  assign src_end = {1'b0, src_i} + 33'(len_i);
  assign dst_end = {1'b0, dst_i} + 33'(len_i);
  assign err_o   = (src_end > 33'(MEM_SIZE)) || (dst_end > 33'(MEM_SIZE));
endmodule

// File: rtl/mem_copy_engine.sv
// Overlap-safe block copier: alternates one read and one write per word over
// the single memory port, walking down when the destination lies above.
module mem_copy_engine #(
  parameter int MEM_SIZE = mem_pkg::MEM_SIZE,
  parameter int LEN_W    = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               src_addr,
  input  logic [31:0]               dst_addr,
  input  logic [LEN_W-1:0]          len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [LEN_W-1:0]          words_done,
  output logic [31:0]               mem_addr,
  output logic [mem_pkg::WORD_W-1:0] mem_din,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [mem_pkg::WORD_W-1:0] mem_dout
);
  import mem_pkg::*;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [31:0]        src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d, wdone_q, wdone_d;
  logic               desc_q, desc_d, err_q, err_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               rng_err;

  mem_copy_range_chk #(.MEM_SIZE(MEM_SIZE), .LEN_W(LEN_W)) u_chk (
    .src_i (src_q),
    .dst_i (dst_q),
    .len_i (len_q),
    .err_o (rng_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wdone_q <= '0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wdone_q <= wdone_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // pend_q marks the cycle after an accepted start: operands are latched and
  // the range check runs on them before any memory access is made.
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wdone_d = wdone_q;
    desc_d  = desc_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (rng_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (len_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = desc_q ? (len_q - ONE) : '0;
            state_d = RD;
          end
        end else if (start) begin
          pend_d  = 1'b1;
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          desc_d  = (dst_addr > src_addr);
          err_d   = 1'b0;
          wdone_d = '0;
        end
      end
      RD: begin
        data_d  = mem_dout;
        state_d = WR;
      end
      WR: begin
        wdone_d = wdone_q + ONE;
        if (wdone_q + ONE == len_q) begin
          state_d = FIN;
        end else begin
          idx_d   = desc_q ? (idx_q - ONE) : (idx_q + ONE);
          state_d = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_re     = (state_q == RD);
  assign mem_we     = (state_q == WR);
  assign mem_addr   = mem_re ? (src_q + 32'(idx_q)) :
                      mem_we ? (dst_q + 32'(idx_q)) : '0;
  assign mem_din    = mem_we ? data_q : '0;
  assign busy       = pend_q || (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign err        = err_q;
  assign words_done = wdone_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a memmove-style reference model predicts
// the read/write sequence and final memory image; a per-cycle monitor checks it.
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [8:0]  len;
  logic        busy, done, err;
  logic [8:0]  words_done;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we, mem_re;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  logic [31:0] mem  [256];
  logic [31:0] gold [256];
  logic        init_req;
  logic [31:0] rq[$];
  wr_t         wq[$];
  wr_t         model_wr[$];
  bit          expect_access;
  int          first_wa, last_wa, last_done_k;
  int          checks = 0;
  int          failures = 0;

  mem_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .words_done(words_done), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem_re ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= gold[i];
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_din;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Per-cycle monitor: strobe legality plus in-order read/write matching.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("strobes_in_reset", {mem_we, mem_re, busy, done}, 0);
    end else begin
      chk("strobe_legal", ((mem_we && mem_re) || ((mem_we || mem_re) && !expect_access)) ? 1 : 0, 0);
      if (mem_re) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", mem_addr, rq.pop_front());
      end
      if (mem_we) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_din, w.d);
        end
        if (first_wa < 0) first_wa = int'(mem_addr);
        last_wa = int'(mem_addr);
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) gold[i] = 32'h0;
    gold[3] = 17; gold[7] = 5; gold[18] = 99;
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
  endtask

  // Reference: memmove semantics, words visited top-down when dst > src.
  task automatic model_setup(input int s, input int d, input int n, output bit exp_err);
    exp_err = (longint'(s) + n > 256) || (longint'(d) + n > 256);
    rq.delete(); wq.delete(); model_wr.delete();
    first_wa = -1; last_wa = -1;
    expect_access = !exp_err && (n > 0);
    if (expect_access) begin
      for (int j = 0; j < n; j++) begin
        int i;
        wr_t w;
        i = (d > s) ? (n - 1 - j) : j;
        rq.push_back(32'(s + i));
        w.a = 32'(d + i);
        w.d = gold[s + i];
        wq.push_back(w);
        model_wr.push_back(w);
      end
    end
  endtask

  task automatic do_copy(input int s, input int d, input int n, input int extra_at);
    bit exp_err, seen, dropped;
    int k, exp_edge, mism;
    model_setup(s, d, n, exp_err);
    exp_edge = (exp_err || n == 0) ? 1 : 2 * n + 1;
    @(negedge clk);
    start = 1'b1; src_addr = 32'(s); dst_addr = 32'(d); len = 9'(n);
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; seen = 1'b0; dropped = 1'b0;
    while (!seen && k < 2 * n + 8) begin
      @(posedge clk);
      #1 k++;
      start = 1'b0;
      if (k == extra_at) begin
        start = 1'b1; src_addr = 32'd0; dst_addr = 32'd200; len = 9'd2;
      end
      if (done) seen = 1'b1;
      else if (!busy) dropped = 1'b1;
    end
    start = 1'b0;
    last_done_k = seen ? k : -1;
    chk("done_edge", last_done_k, exp_edge);
    chk("err_at_done", err, exp_err);
    chk("busy_at_done", busy, 1);
    chk("busy_continuous", dropped, 0);
    chk("words_done_at_done", words_done, exp_err ? 0 : n);
    foreach (model_wr[i]) gold[model_wr[i].a[7:0]] = model_wr[i].d;
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_fin", busy, 0);
    chk("words_done_hold", words_done, exp_err ? 0 : n);
    chk("reads_left", rq.size(), 0);
    chk("writes_left", wq.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) mism++;
    chk("mem_image", mism, 0);
    expect_access = 1'b0;
  endtask

  initial begin
    bit dummy;
    int mism;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    init_req = 1'b0; expect_access = 1'b0; first_wa = -1; last_wa = -1;
    init_mem();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words_done", words_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);

    // block copy into a disjoint region
    do_copy(3, 20, 5, 0);
    chk("lit_fwd_done_edge", last_done_k, 11);
    chk("lit_mem20", mem[20], 17);
    chk("lit_mem24", mem[24], 5);
    chk("lit_mem22", mem[22], 0);
    chk("lit_fwd_words", words_done, 5);

    // overlapping, destination above source
    init_mem();
    do_copy(3, 5, 5, 0);
    chk("lit_mem5", mem[5], 17);
    chk("lit_mem9", mem[9], 5);
    chk("lit_mem7", mem[7], 0);
    chk("lit_first_wa", first_wa, 9);
    chk("lit_last_wa", last_wa, 5);

    // overlapping, destination below source
    init_mem();
    do_copy(18, 16, 3, 0);
    chk("lit_mem16", mem[16], 99);
    chk("lit_mem17", mem[17], 0);
    chk("lit_mem18", mem[18], 0);

    // out-of-range source: error completion, no access
    init_mem();
    do_copy(250, 0, 10, 0);
    chk("lit_err_done_edge", last_done_k, 1);
    chk("lit_err_set", err, 1);
    repeat (3) @(posedge clk);
    #1 chk("err_held", err, 1);

    // empty request clears err
    do_copy(10, 20, 0, 0);
    chk("lit_empty_done_edge", last_done_k, 1);
    chk("lit_empty_err", err, 0);

    // second start mid-copy must be ignored
    init_mem();
    do_copy(0, 100, 4, 3);
    chk("lit_busy_mem103", mem[103], 17);
    chk("lit_busy_mem200", mem[200], 0);

    // reset during the write of word 2 (descending, so word 1 went to 24)
    init_mem();
    model_setup(3, 20, 5, dummy);
    @(negedge clk);
    start = 1'b1; src_addr = 32'd3; dst_addr = 32'd20; len = 9'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_we", mem_we, 1);
    chk("pre_rst_addr", mem_addr, 23);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_re", mem_re, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_din", mem_din, 0);
    chk("arst_words_done", words_done, 0);
    rq.delete(); wq.delete();
    expect_access = 1'b0;
    gold[model_wr[0].a[7:0]] = model_wr[0].d;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("lit_rst_mem24", mem[24], 5);
    chk("lit_rst_mem23", mem[23], 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) mism++;
    chk("rst_mem_image", mism, 0);

    // engine usable again after reset
    do_copy(7, 3, 2, 0);
    chk("lit_after_rst_mem3", mem[3], 5);
    chk("lit_after_rst_mem4", mem[4], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
